compress_sched: RTL and testbench

COMPRESS_SCHED -- requirements
Module: compress_sched

---
 rtl/compress_pkg.sv | 23 ++
 rtl/csa_row.sv | 22 ++
 rtl/compress_sched.sv | 134 +++++++++++++
 tb/tb_compress_sched.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/compress_pkg.sv
// Shared definitions for the carry-save accumulator scheduler.
//   state_t   : FSM state encoding (IDLE, ACCUM, RESOLVE, OUTPUT)
//   calc_aw   : accumulator width for a given operand width and job size
//   calc_nch  : number of resolve slices for a given width and slice size
package compress_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    OUTPUT  = 2'd3
  } state_t;

  // Enough headroom that NOPS_MAX full-scale operands never wrap.
  function automatic int calc_aw(input int w, input int nops_max);
    return w + $clog2(nops_max);
  endfunction

  function automatic int calc_nch(input int aw, input int chunk);
    return (aw + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/csa_row.sv
// One row of 3:2 carry-save compressors, purely combinational.
//   a, b, d : three W-bit addends
//   sum     : bitwise sum without carries (a ^ b ^ d)
//   carry   : majority bits shifted up one place, top bit dropped
// sum + carry == a + b + d (mod 2^W).
module csa_row #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] d,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  logic [W-1:0] maj;

  assign sum   = a ^ b ^ d;
  assign maj   = (a & b) | (a & d) | (b & d);
  assign carry = maj << 1;

endmodule

// File: rtl/compress_sched.sv
// Streams unsigned operands into a carry-save accumulator, then resolves
// the redundant sum with a narrow adder one CHUNK-bit slice per cycle.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : operand handshake; in_data operand, in_last ends job
//   out_valid/out_ready : result handshake; out_data sum mod 2^AW,
//                         out_ovf set when the job exceeded NOPS_MAX operands
//   busy                : FSM is not IDLE
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// A producer holds valid and its payload until that edge; ready may depend
// only on the receiver's state, never combinationally on valid.
module compress_sched
  import compress_pkg::*;
#(
  parameter  int W        = 64,
  parameter  int NOPS_MAX = 16,
  parameter  int CHUNK    = 17,
  localparam int AW       = calc_aw(W, NOPS_MAX)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_data,
  output logic          out_ovf,
  output logic          busy
);

  localparam int NCH = calc_nch(AW, CHUNK);
  localparam int PW  = NCH * CHUNK;               // slice-aligned width
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW  = $clog2(NOPS_MAX + 2);      // holds NOPS_MAX+1

  state_t          state;
  logic [AW-1:0]   s, c;
  logic [CW-1:0]   count;
  logic            ovf;
  logic [IW-1:0]   idx;
  logic            carry;
  logic [PW-1:0]   res;

  logic [AW-1:0]   x, s_nxt, c_nxt;
  logic [PW-1:0]   s_pad, c_pad;
  logic [CHUNK-1:0] s_sl, c_sl;
  logic [CHUNK:0]  sl_sum;

  assign x = AW'(in_data);

  csa_row #(.W(AW)) u_row (
    .a     (s),
    .b     (c),
    .d     (x),
    .sum   (s_nxt),
    .carry (c_nxt)
  );

  // Current resolve slice; padding covers AW not being a multiple of CHUNK.
  assign s_pad  = PW'(s);
  assign c_pad  = PW'(c);
  assign s_sl   = s_pad[idx*CHUNK +: CHUNK];
  assign c_sl   = c_pad[idx*CHUNK +: CHUNK];
  assign sl_sum = {1'b0, s_sl} + {1'b0, c_sl} + {{CHUNK{1'b0}}, carry};

  assign in_ready  = (state == IDLE) || (state == ACCUM);
  assign out_valid = (state == OUTPUT);
  assign busy      = (state != IDLE);
  assign out_data  = res[AW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      s       <= '0;
      c       <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      idx     <= '0;
      carry   <= 1'b0;
      res     <= '0;
      out_ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            s     <= x;
            c     <= '0;
            count <= CW'(1);
            ovf   <= 1'b0;
            idx   <= '0;
            carry <= 1'b0;
            state <= in_last ? RESOLVE : ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            s <= s_nxt;
            c <= c_nxt;
            // Saturate one past the limit so the flag stays meaningful.
            if (count >= CW'(NOPS_MAX)) begin
              count <= CW'(NOPS_MAX + 1);
              ovf   <= 1'b1;
            end else begin
              count <= count + CW'(1);
            end
            if (in_last) begin
              idx   <= '0;
              carry <= 1'b0;
              state <= RESOLVE;
            end
          end
        end
        RESOLVE: begin
          res[idx*CHUNK +: CHUNK] <= sl_sum[CHUNK-1:0];
          carry                   <= sl_sum[CHUNK];
          if (idx == IW'(NCH - 1)) begin
            idx     <= '0;
            out_ovf <= ovf;
            state   <= OUTPUT;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        OUTPUT: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_compress_sched.sv
module tb_compress_sched;

  localparam int W   = 64;
  localparam int AW  = 68;
  localparam int NCH = 4;
  localparam int NOPS_MAX = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_data;
  logic          out_ovf;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] ops_q[$];
  logic [AW:0]  exp_q[$];   // {ovf, data}

  typedef struct {
    logic [W-1:0]  first_op;
    logic [W-1:0]  rest_op;
    int            n;
    int            hold;
    logic [AW-1:0] exp_data;
    logic          exp_ovf;
  } vec_t;

  vec_t vecs[6];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  compress_sched dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference model: plain wide-integer sum of the job, wrapped to AW bits.
  function automatic logic [AW:0] model_job();
    logic [AW+8:0] acc;
    acc = '0;
    foreach (ops_q[i]) acc = acc + (AW+9)'(ops_q[i]);
    return {(ops_q.size() > NOPS_MAX), acc[AW-1:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- drivers ----------------
  // Sends ops_q as one job; returns just after the edge accepting in_last.
  task automatic send_job(input int gap_max);
    int w;
    for (int i = 0; i < ops_q.size(); i++) begin
      int gaps;
      gaps = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      for (int g = 0; g < gaps; g++) begin
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
        in_last  = 1'($urandom_range(0, 1));
        tick();
      end
      in_valid = 1'b1;
      in_data  = ops_q[i];
      in_last  = (i == ops_q.size() - 1);
      w = 0;
      while (!in_ready && w < 50) begin
        tick();
        w++;
      end
      if (w >= 50) check("in_ready_timeout", 0, 1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = {$urandom, $urandom};
  endtask

  // Waits for the result, applies back-pressure, checks against exp_q.
  task automatic recv_job(input int hold);
    int lat;
    logic [AW-1:0] d0;
    logic          o0;
    logic [AW:0]   e;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", lat, NCH);
    check("in_ready_in_output", in_ready, 0);
    check("busy_in_output", busy, 1);
    d0 = out_data;
    o0 = out_ovf;
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      tick();
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, d0);
      check("hold_ovf", out_ovf, o0);
      check("hold_in_ready", in_ready, 0);
    end
    e = exp_q.pop_front();
    check("out_data", out_data, e[AW-1:0]);
    check("out_ovf", out_ovf, e[AW]);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_hs_valid", out_valid, 0);
    check("post_hs_in_ready", in_ready, 1);
    check("post_hs_busy", busy, 0);
  endtask

  // ---------------- test ----------------
  initial begin
    vecs[0] = '{64'h5, 64'h0, 1, 0, 68'h5, 1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 16, 1,
                68'hF_FFFF_FFFF_FFFF_FFF0, 1'b0};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 17, 2,
                68'h0_FFFF_FFFF_FFFF_FFEF, 1'b1};
    vecs[3] = '{64'h1FFFF, 64'h1, 2, 5, 68'h20000, 1'b0};
    vecs[4] = '{64'h3, 64'h4, 2, 0, 68'h7, 1'b0};
    vecs[5] = '{64'h1, 64'h1, 20, 0, 68'd20, 1'b1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ovf", out_ovf, 0);
    rst = 1'b0;
    tick();

    // Directed table.
    for (int v = 0; v < 6; v++) begin
      ops_q.delete();
      ops_q.push_back(vecs[v].first_op);
      for (int k = 1; k < vecs[v].n; k++) ops_q.push_back(vecs[v].rest_op);
      exp_q.push_back({vecs[v].exp_ovf, vecs[v].exp_data});
      send_job(0);
      recv_job(vecs[v].hold);
    end

    // Reset during the second resolve cycle discards the job.
    ops_q.delete();
    ops_q.push_back(64'h1234);
    ops_q.push_back(64'h5678);
    send_job(0);
    tick();
    rst = 1'b1;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_busy", busy, 0);
    tick();
    rst = 1'b0;
    tick();
    check("postrst_valid", out_valid, 0);
    check("postrst_in_ready", in_ready, 1);
    check("postrst_data", out_data, 0);
    ops_q.delete();
    ops_q.push_back(64'h3);
    ops_q.push_back(64'h4);
    exp_q.push_back({1'b0, 68'h7});
    send_job(0);
    recv_job(0);

    // Randomized jobs against the reference model.
    for (int j = 0; j < 30; j++) begin
      int n;
      n = $urandom_range(1, 20);
      ops_q.delete();
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 3) == 0) ops_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        else ops_q.push_back({$urandom, $urandom});
      end
      exp_q.push_back(model_job());
      send_job(2);
      recv_job($urandom_range(0, 3));
    end

    check("exp_q_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
